// File: rtl/conv_pkg.sv
// Shared types for the 2x2 window generator: pixel/window packing and FSM states.
package conv_pkg;

  localparam int PIX_W     = 8;
  localparam int WIN_LANES = 4;

  typedef logic [PIX_W-1:0]                 pix_t;
  typedef logic [WIN_LANES-1:0][PIX_W-1:0]  win_t;

  typedef enum logic [1:0] {
    IDLE,
    FIRST_ROW,
    STREAM
  } win_state_e;

  // Counter width that stays legal for a depth of 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// Single-row pixel buffer: combinational read of the old entry, write of the new one at the same address.
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_addr,
  input  pix_t          i_wr_dat,
  output pix_t          o_rd_dat
);

  pix_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_addr] <= i_wr_dat;
    end
  end

  assign o_rd_dat = r_mem[i_addr];

endmodule

// File: rtl/conv_window_gen.sv
// 2x2 raster window generator; windows are registered one cycle after the bottom-right pixel.
// No backpressure: pix_valid low stalls everything. WIN_STRIDE2_EN selects stride-2 windows.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PIX_W-1:0]                pix_in,
  input  logic                            pix_valid,
  input  logic                            pix_sof,
  output logic [WIN_LANES-1:0][PIX_W-1:0] win_pixels,
  output logic                            win_valid,
  output logic                            frame_done,
  output logic                            busy
);

  localparam int CW = cnt_w(IMG_WIDTH);
  localparam int RW = cnt_w(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  win_state_e    r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  pix_t          r_prev_top;
  pix_t          r_prev_bot;
  win_t          r_win;
  logic          r_win_vld;
  logic          r_done;

  logic          w_take;
  logic          w_in_stream;
  logic          w_stride_ok;
  logic          w_elig;
  logic          w_eol;
  logic          w_eof;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  pix_t          w_top;

  // A sof pixel is always position (0,0), whatever the counters held before.
  assign w_take      = pix_valid & (pix_sof | (r_state != IDLE));
  assign w_col       = pix_sof ? '0 : r_col;
  assign w_row       = pix_sof ? '0 : r_row;
  assign w_in_stream = !pix_sof && (r_state == STREAM);

`ifdef WIN_STRIDE2_EN
  assign w_stride_ok = r_row[0] & r_col[0];
`else
  assign w_stride_ok = 1'b1;
`endif

  assign w_elig = w_take & w_in_stream & (r_col != '0) & w_stride_ok;
  assign w_eol  = (w_col == COL_LAST);
  assign w_eof  = w_in_stream & w_eol & (r_row == ROW_LAST);

  conv_line_buf #(
    .DEPTH (IMG_WIDTH),
    .AW    (CW)
  ) u_line_buf (
    .clk      (clk),
    .i_wr_en  (w_take),
    .i_addr   (w_col),
    .i_wr_dat (pix_in),
    .o_rd_dat (w_top)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_prev_top <= '0;
      r_prev_bot <= '0;
      r_win      <= '0;
      r_win_vld  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_win_vld <= w_elig;
      r_done    <= w_take & w_eof;
      if (w_elig) begin
        r_win <= {pix_in, r_prev_bot, w_top, r_prev_top};
      end
      if (w_take) begin
        r_prev_top <= w_top;
        r_prev_bot <= pix_in;
        if (w_eol) begin
          r_col <= '0;
          r_row <= w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
        if (w_eof) begin
          r_state <= IDLE;
          r_row   <= '0;
        end else if (w_eol) begin
          r_state <= STREAM;
        end else if (pix_sof) begin
          r_state <= FIRST_ROW;
        end
      end
    end
  end

  assign win_pixels = r_win;
  assign win_valid  = r_win_vld;
  assign frame_done = r_done;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen on a 4x4 image: array-based reference model plus directed frames.
module tb_conv_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pix_valid = 1'b0;
  logic             pix_sof = 1'b0;
  logic [7:0]       pix_in = 8'h0;
  logic [3:0][7:0]  win_pixels;
  logic             win_valid;
  logic             frame_done;
  logic             busy;

  conv_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .win_pixels (win_pixels),
    .win_valid  (win_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers the current frame as a 2-D image and
  // derives each window directly from its four neighbouring pixels.
  logic [7:0]       img [H][W];
  int               m_r = 0;
  int               m_c = 0;
  bit               m_act = 1'b0;
  logic             exp_vld = 1'b0;
  logic             exp_done = 1'b0;
  logic [3:0][7:0]  exp_win = '0;
  bit               stride_ok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act    = 1'b0;
      exp_vld  = 1'b0;
      exp_done = 1'b0;
      exp_win  = '0;
    end else begin
      exp_vld  = 1'b0;
      exp_done = 1'b0;
      if (pix_valid) begin
        if (pix_sof) begin
          m_act = 1'b1;
          m_r   = 0;
          m_c   = 0;
        end
        if (m_act) begin
          img[m_r][m_c] = pix_in;
`ifdef WIN_STRIDE2_EN
          stride_ok = (m_r % 2 == 1) && (m_c % 2 == 1);
`else
          stride_ok = 1'b1;
`endif
          if (m_r >= 1 && m_c >= 1 && stride_ok) begin
            exp_vld = 1'b1;
            exp_win = {img[m_r][m_c], img[m_r][m_c-1], img[m_r-1][m_c], img[m_r-1][m_c-1]};
          end
          if (m_r == H-1 && m_c == W-1) begin
            exp_done = 1'b1;
            m_act    = 1'b0;
          end
          m_c++;
          if (m_c == W) begin
            m_c = 0;
            m_r++;
          end
        end
      end
    end
  end

  // Per-cycle compare plus a log of every window the DUT emits.
  logic [32:0] wlog[$];
  bit          prev_vld = 1'b0;
  int          b2b = 0;

  always @(negedge clk) begin
    check("win_valid", 64'(win_valid), 64'(exp_vld));
    check("frame_done", 64'(frame_done), 64'(exp_done));
    check("win_pixels", 64'(win_pixels), 64'(exp_win));
    check("busy", 64'(busy), 64'(m_act));
    if (win_valid) begin
      wlog.push_back({frame_done, win_pixels});
      if (prev_vld) b2b++;
    end
    prev_vld = win_valid;
  end

  function automatic logic [32:0] logat(input int i);
    return (i < wlog.size()) ? wlog[i] : 33'h0;
  endfunction

  function automatic int done_count();
    int n = 0;
    foreach (wlog[i]) if (wlog[i][32]) n++;
    return n;
  endfunction

  task automatic cyc(input logic v, input logic s, input logic [7:0] p);
    pix_valid = v;
    pix_sof   = s;
    pix_in    = p;
    @(negedge clk);
  endtask

  task automatic send_pixels(input int base, input int npix, input bit tog);
    for (int i = 0; i < npix; i++) begin
      cyc(1'b1, i == 0, 8'(base + i));
      if (tog) cyc(1'b0, 1'b0, 8'hEE);
    end
  endtask

  task automatic flush();
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
  endtask

`ifdef WIN_STRIDE2_EN
  localparam int N_WIN  = 4;
  localparam int N_ABRT = 2;
`else
  localparam int N_WIN  = 9;
  localparam int N_ABRT = 3;
`endif

  initial begin
    repeat (2) @(negedge clk);
    check("rst_win_pixels", 64'(win_pixels), 64'h0);
    check("rst_win_valid", 64'(win_valid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);

    // Ramp frame, continuous valid.
    wlog.delete();
    send_pixels(0, W*H, 1'b0);
    flush();
    check("ramp_count", 64'(wlog.size()), 64'(N_WIN));
    check("ramp_first", 64'(logat(0)), {31'h0, 1'b0, 32'h05040100});
`ifdef WIN_STRIDE2_EN
    check("ramp_s2_w1", 64'(logat(1)), {31'h0, 1'b0, 32'h07060302});
    check("ramp_s2_w2", 64'(logat(2)), {31'h0, 1'b0, 32'h0D0C0908});
`endif
    check("ramp_last", 64'(logat(N_WIN-1)), {31'h0, 1'b1, 32'h0F0E0B0A});

    // Same frame with valid toggling.
    wlog.delete();
    b2b = 0;
    send_pixels(0, W*H, 1'b1);
    flush();
    check("tog_count", 64'(wlog.size()), 64'(N_WIN));
    check("tog_first", 64'(logat(0)), {31'h0, 1'b0, 32'h05040100});
    check("tog_last", 64'(logat(N_WIN-1)), {31'h0, 1'b1, 32'h0F0E0B0A});
    check("tog_back_to_back", 64'(b2b), 64'h0);

    // Pixels without sof while idle are dropped.
    wlog.delete();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(50 + i));
    check("nosof_count", 64'(wlog.size()), 64'h0);
    check("nosof_busy", 64'(busy), 64'h0);
    send_pixels(0, W*H, 1'b0);
    flush();
    check("nosof_frame_count", 64'(wlog.size()), 64'(N_WIN));

    // Restart at pixel (2,1) with a new frame.
    wlog.delete();
    send_pixels(0, 2*W + 1, 1'b0);
    send_pixels(100, W*H, 1'b0);
    flush();
    check("restart_count", 64'(wlog.size()), 64'(N_ABRT + N_WIN));
    check("restart_done_cnt", 64'(done_count()), 64'h1);
    check("restart_first_new", 64'(logat(N_ABRT)), {31'h0, 1'b0, 32'h69686564});

    // Back-to-back frames with no gap.
    wlog.delete();
    send_pixels(0, W*H, 1'b0);
    send_pixels(16, W*H, 1'b0);
    flush();
    check("b2b_count", 64'(wlog.size()), 64'(2*N_WIN));
    check("b2b_second_first", 64'(logat(N_WIN)), {31'h0, 1'b0, 32'h15141110});
    check("b2b_done_cnt", 64'(done_count()), 64'h2);

    // Asynchronous reset right after a window appears.
    send_pixels(0, 3*W - 1, 1'b0);
    check("pre_rst_valid", 64'(win_valid), 64'(exp_vld));
    #2 rst_n = 1'b0;
    #1;
    check("arst_win_valid", 64'(win_valid), 64'h0);
    check("arst_win_pixels", 64'(win_pixels), 64'h0);
    check("arst_busy", 64'(busy), 64'h0);
    pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    wlog.delete();
    send_pixels(0, W*H, 1'b0);
    flush();
    check("post_rst_count", 64'(wlog.size()), 64'(N_WIN));
    check("post_rst_first", 64'(logat(0)), {31'h0, 1'b0, 32'h05040100});
    check("post_rst_last", 64'(logat(N_WIN-1)), {31'h0, 1'b1, 32'h0F0E0B0A});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
